move_entry: RTL and testbench

Input conditioning and move-validation stage that sits directly upstream of the game-control FSM. It synchronizes and debounces the raw active-low `enter_L` and `newGame_L` buttons, and synchronizes the 4-bit `hMove` switch bank. Each accepted press becomes exactly one single-cycle strobe: `moveValid` for a legal move, `moveError` for an illegal one, or `newGame`. The game FSM consumes only these clean strobes and never touches raw buttons.

---
 rtl/move_entry.sv | 137 +++++++++++++
 tb/tb_move_entry.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/move_entry.sv
// move_entry: synchronizes and debounces the enter/new-game buttons
// and turns each accepted press into one validated single-cycle strobe.
module move_entry #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enter_L,
   input  logic       newGame_L,
   input  logic [3:0] hMove,
   input  logic [8:0] taken,
   input  logic       busy,
   output logic [3:0] move,
   output logic       moveValid,
   output logic       moveError,
   output logic       newGame
);

   typedef enum logic [1:0] {IDLE, CHECK, HOLD} state_t;

   localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

   logic        enMeta, enSyncL;
   logic        ngMeta, ngSyncL;
   logic [3:0]  hMeta, hSync;
   logic        enSync, ngSync;
   logic [7:0]  enCnt, ngCnt;
   logic        enDb, ngDb;
   logic        enDbPrev, ngDbPrev;
   logic        enRise, ngRise;
   logic [15:0] takenX;
   logic [3:0]  idx;
   logic        legal;
   state_t      state;

   // two-flop synchronizers; buttons come out of reset released
   always_ff @(posedge clock) begin
      if (reset) begin
         enMeta  <= 1'b1;
         enSyncL <= 1'b1;
         ngMeta  <= 1'b1;
         ngSyncL <= 1'b1;
         hMeta   <= 4'd0;
         hSync   <= 4'd0;
      end else begin
         enMeta  <= enter_L;
         enSyncL <= enMeta;
         ngMeta  <= newGame_L;
         ngSyncL <= ngMeta;
         hMeta   <= hMove;
         hSync   <= hMeta;
      end
   end

   assign enSync = ~enSyncL;
   assign ngSync = ~ngSyncL;

   // enter debouncer: level must differ for DEBOUNCE_CYCLES cycles
   always_ff @(posedge clock) begin
      if (reset) begin
         enCnt    <= 8'd0;
         enDb     <= 1'b0;
         enDbPrev <= 1'b0;
      end else begin
         enDbPrev <= enDb;
         if (enSync == enDb) begin
            enCnt <= 8'd0;
         end else if (enCnt == LAST) begin
            enDb  <= ~enDb;
            enCnt <= 8'd0;
         end else begin
            enCnt <= enCnt + 8'd1;
         end
      end
   end

   // new-game debouncer, same scheme as enter
   always_ff @(posedge clock) begin
      if (reset) begin
         ngCnt    <= 8'd0;
         ngDb     <= 1'b0;
         ngDbPrev <= 1'b0;
      end else begin
         ngDbPrev <= ngDb;
         if (ngSync == ngDb) begin
            ngCnt <= 8'd0;
         end else if (ngCnt == LAST) begin
            ngDb  <= ~ngDb;
            ngCnt <= 8'd0;
         end else begin
            ngCnt <= ngCnt + 8'd1;
         end
      end
   end

   assign enRise = enDb & ~enDbPrev;
   assign ngRise = ngDb & ~ngDbPrev;

   // zero-padded so out-of-range move values never index past taken
   assign takenX = {7'd0, taken};
   assign idx    = hSync - 4'd1;
   assign legal  = (hSync != 4'd0) && (hSync <= 4'd9) &&
                   !takenX[idx] && !busy;

   // enter FSM; strobes are registered alongside the IDLE->CHECK move
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         move      <= 4'd0;
         moveValid <= 1'b0;
         moveError <= 1'b0;
         newGame   <= 1'b0;
      end else begin
         moveValid <= 1'b0;
         moveError <= 1'b0;
         newGame   <= ngRise;
         case (state)
            IDLE: begin
               if (enRise && ngRise) begin
                  state <= HOLD;
               end else if (enRise) begin
                  state     <= CHECK;
                  move      <= hSync;
                  moveValid <= legal;
                  moveError <= ~legal;
               end
            end
            CHECK: state <= HOLD;
            HOLD: begin
               if (!enDb) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_move_entry.sv
// tb_move_entry: directed presses with a queue-based scoreboard;
// the monitor pops one expected strobe per observed strobe.
module tb_move_entry;

   localparam int K_VALID = 0;
   localparam int K_ERR   = 1;
   localparam int K_NG    = 2;

   typedef struct {
      int       kind;
      logic [3:0] mv;
      int       at;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       enter_L;
   logic       newGame_L;
   logic [3:0] hMove;
   logic [8:0] taken;
   logic       busy;
   logic [3:0] move;
   logic       moveValid;
   logic       moveError;
   logic       newGame;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   exp_t q[$];

   move_entry #(.DEBOUNCE_CYCLES(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .enter_L   (enter_L),
      .newGame_L (newGame_L),
      .hMove     (hMove),
      .taken     (taken),
      .busy      (busy),
      .move      (move),
      .moveValid (moveValid),
      .moveError (moveError),
      .newGame   (newGame)
   );

   initial forever #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // monitor: every strobe must match the head of the expectation queue
   always @(negedge clock) begin : mon
      exp_t e;
      int   k;
      if (moveValid || moveError || newGame) begin
         checks++;
         if ((moveValid && moveError) ||
             (newGame && (moveValid || moveError))) begin
            errors++;
            $display("FAIL excl: cyc=%0d valid=%b err=%b ng=%b",
                     cyc, moveValid, moveError, newGame);
         end
         k = newGame ? K_NG : (moveError ? K_ERR : K_VALID);
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected: cyc=%0d kind=%0d move=%0d",
                     cyc, k, move);
         end else begin
            e = q.pop_front();
            if (e.kind != k || e.at != cyc ||
                (k != K_NG && e.mv != move)) begin
               errors++;
               $display("FAIL strobe: got kind=%0d cyc=%0d move=%0d, want kind=%0d cyc=%0d move=%0d",
                        k, cyc, move, e.kind, e.at, e.mv);
            end
         end
      end
   end

   task automatic check_zero(input string name);
      checks++;
      if ({move, moveValid, moveError, newGame} != 7'd0) begin
         errors++;
         $display("FAIL %s: move=%0d v=%b e=%b ng=%b, want all 0",
                  name, move, moveValid, moveError, newGame);
      end
   endtask

   // called at a negedge; leaves the caller at a negedge
   task automatic press(input int len, input int gap,
                        input logic [3:0] hm, input logic [8:0] tk,
                        input logic bs, input int kind);
      hMove   = hm;
      taken   = tk;
      busy    = bs;
      enter_L = 1'b0;
      q.push_back('{kind, hm, cyc + 7});
      repeat (len) @(negedge clock);
      enter_L = 1'b1;
      repeat (gap) @(negedge clock);
   endtask

   initial begin
      reset     = 1'b1;
      enter_L   = 1'b1;
      newGame_L = 1'b1;
      hMove     = 4'd0;
      taken     = 9'd0;
      busy      = 1'b0;
      repeat (3) @(negedge clock);
      check_zero("reset_init");
      reset = 1'b0;

      // legal move held for 10 cycles, no repeat strobe
      press(10, 12, 4'd6, 9'b000010000, 1'b0, K_VALID);
      checks++;
      if (move != 4'd6) begin
         errors++;
         $display("FAIL move_hold: got %0d want 6", move);
      end

      // illegal moves
      press(6, 12, 4'd5, 9'b000010000, 1'b0, K_ERR);
      press(6, 12, 4'd0, 9'd0, 1'b0, K_ERR);
      press(6, 12, 4'd12, 9'd0, 1'b0, K_ERR);
      press(6, 12, 4'd3, 9'd0, 1'b1, K_ERR);
      busy = 1'b0;

      // bounce: never D consecutive cycles, no strobe
      hMove   = 4'd7;
      enter_L = 1'b0;
      repeat (2) @(negedge clock);
      enter_L = 1'b1;
      repeat (1) @(negedge clock);
      enter_L = 1'b0;
      repeat (2) @(negedge clock);
      enter_L = 1'b1;
      repeat (10) @(negedge clock);
      press(6, 12, 4'd7, 9'd0, 1'b0, K_VALID);

      // simultaneous buttons: newGame wins
      hMove     = 4'd4;
      taken     = 9'd0;
      enter_L   = 1'b0;
      newGame_L = 1'b0;
      q.push_back('{K_NG, 4'd4, cyc + 7});
      repeat (6) @(negedge clock);
      enter_L   = 1'b1;
      newGame_L = 1'b1;
      repeat (12) @(negedge clock);
      press(6, 12, 4'd4, 9'd0, 1'b0, K_VALID);

      // reset during a held press
      hMove   = 4'd8;
      enter_L = 1'b0;
      repeat (4) @(negedge clock);
      reset = 1'b1;
      repeat (1) @(negedge clock);
      check_zero("reset_mid_a");
      repeat (1) @(negedge clock);
      check_zero("reset_mid_b");
      repeat (1) @(negedge clock);
      check_zero("reset_mid_c");
      reset = 1'b0;
      q.push_back('{K_VALID, 4'd8, cyc + 7});
      repeat (8) @(negedge clock);
      enter_L = 1'b1;
      repeat (12) @(negedge clock);

      // back-to-back presses
      press(6, 6, 4'd9, 9'd0, 1'b0, K_VALID);
      press(6, 12, 4'd1, 9'd0, 1'b0, K_VALID);

      repeat (5) @(negedge clock);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL missing: %0d strobes outstanding, want 0",
                  q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
